// File: rtl/mips_boot_sequencer_pkg.sv
// Shared definitions for the MIPS boot sequencer and the instruction memory model.
//   boot_state_e   : sequencer state encoding (LOAD, RELEASE, RUN, ERROR)
//   IMEM_DEPTH_DEF : default instruction memory depth in 32-bit words
//   ADDR_W_DEF     : default word-address width, clog2(IMEM_DEPTH_DEF)
package mips_boot_sequencer_pkg;

  localparam int unsigned IMEM_DEPTH_DEF = 64;
  localparam int unsigned ADDR_W_DEF     = 6;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ERROR   = 2'd3
  } boot_state_e;

endpackage

// File: rtl/mips_boot_sequencer_assembler.sv
// boot_word_assembler: collects loader bytes big-endian into 32-bit words.
// Ports:
//   clk_i        : system clock, rising edge
//   reset_i      : synchronous active-high reset (discards any partial word)
//   clear_i      : synchronous clear at the start of a new boot
//   accept_i     : a loader byte is transferred this cycle
//   byte_i       : loader byte
//   word_o       : completed word; valid when word_done_o is high
//   byte_idx_o   : position of the next byte within the word (0..3)
//   word_done_o  : the byte accepted this cycle completes a word
module boot_word_assembler
  import mips_boot_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  byte_idx_o,
  output logic        word_done_o
);

  // Only the first three bytes are stored; the fourth is taken straight from
  // the input so the word is available in the cycle it completes.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q,   idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (accept_i) begin
      shift_d = {shift_q[15:0], byte_i};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o      = {shift_q, byte_i};
  assign byte_idx_o  = idx_q;
  assign word_done_o = accept_i && (idx_q == 2'd3);

endmodule

// File: rtl/mips_boot_sequencer.sv
// mips_boot_sequencer: holds the MIPS core in reset while a byte-serial image
// is loaded into instruction memory, then releases the core.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start               : re-boot request, honoured in RUN and ERROR
//   ld_valid/ld_byte/ld_last/ld_ready : loader byte stream handshake
//   imem_we/imem_addr/imem_wdata      : instruction memory write port
//   cpu_reset_n         : active-low reset to the core
//   boot_done, boot_err : RUN / ERROR status
//   words_loaded        : words written in the current boot
// Optional build macro BOOT_CHECKSUM_EN: the final word of the image is an XOR
// checksum of the written words; it is verified instead of being written.
module mips_boot_sequencer
  import mips_boot_sequencer_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned RST_HOLD   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_n,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   words_loaded
);

  boot_state_e       state_q, state_d;
  logic [3:0]        hold_q, hold_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rn_q, rn_d, done_q, done_d, err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]       xor_q, xor_d;
`endif

  logic        accept, restart, do_write, word_done, overflow;
  logic [1:0]  byte_idx;
  logic [31:0] word;

  assign ld_ready = (state_q == ST_LOAD) && !reset;
  assign accept   = ld_valid && ld_ready;
  assign restart  = start && ((state_q == ST_RUN) || (state_q == ST_ERROR));
  assign overflow = (cnt_q == (ADDR_W+1)'(IMEM_DEPTH));

  boot_word_assembler u_asm (
    .clk_i       (clk),
    .reset_i     (reset),
    .clear_i     (restart),
    .accept_i    (accept),
    .byte_i      (ld_byte),
    .word_o      (word),
    .byte_idx_o  (byte_idx),
    .word_done_o (word_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; do_write marks a word that is committed to memory
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    do_write = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        hold_d = '0;
        if (accept && ld_last && (byte_idx != 2'd3)) begin
          state_d = ST_ERROR;
        end else if (word_done) begin
`ifdef BOOT_CHECKSUM_EN
          // Checked before overflow so a checksum at index IMEM_DEPTH is legal.
          if (ld_last) begin
            state_d = (word == xor_q) ? ST_RELEASE : ST_ERROR;
          end else if (overflow) begin
            state_d = ST_ERROR;
          end else begin
            do_write = 1'b1;
          end
`else
          if (overflow) begin
            state_d = ST_ERROR;
          end else begin
            do_write = 1'b1;
            if (ld_last) state_d = ST_RELEASE;
          end
`endif
        end
      end
      ST_RELEASE: begin
        if (hold_q == 4'(RST_HOLD)) state_d = ST_RUN;
        else                        hold_d  = hold_q + 4'd1;
      end
      ST_RUN, ST_ERROR: begin
        if (start) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Registered-output next values, derived from the upcoming state
  always_comb begin
    we_d    = do_write;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (restart) begin
      addr_d  = '0;
      wdata_d = '0;
      cnt_d   = '0;
    end else if (do_write) begin
      addr_d  = cnt_q[ADDR_W-1:0];
      wdata_d = word;
      cnt_d   = cnt_q + (ADDR_W+1)'(1);
    end
    rn_d   = (state_d == ST_RUN);
    done_d = (state_d == ST_RUN);
    err_d  = (state_d == ST_ERROR);
`ifdef BOOT_CHECKSUM_EN
    xor_d = xor_q;
    if (restart)       xor_d = '0;
    else if (do_write) xor_d = xor_q ^ word;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rn_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rn_q    <= rn_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = cnt_q;
  assign cpu_reset_n  = rn_q;
  assign boot_done    = done_q;
  assign boot_err     = err_q;

endmodule

// File: tb/tb_mips_boot_sequencer.sv
// Scoreboard bench for mips_boot_sequencer. A reference model turns each byte
// image into the expected memory writes and final status; a monitor checks
// every imem_we pulse against the queued expectations.
`timescale 1ns/1ps
module tb_mips_boot_sequencer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int HOLD  = 4;

  logic          clk = 1'b0;
  logic          reset, start, ld_valid, ld_last;
  logic [7:0]    ld_byte;
  logic          ld_ready, imem_we, cpu_reset_n, boot_done, boot_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  mips_boot_sequencer #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .RST_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n), .boot_done(boot_done), .boot_err(boot_err),
    .words_loaded(words_loaded)
  );

  typedef struct { int addr; logic [31:0] data; } wr_t;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, rise_cyc = -1, last_acc_cyc = 0;
  logic        prev_rn = 1'b0;
  wr_t         sb[$];
  logic [7:0]  img[$];
  logic [31:0] words[$];
  bit          has_last, exp_err;
  int          n_send, exp_words;

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!reset) begin
      if (imem_we) begin
        if (sb.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = sb.pop_front();
          chk("wr_addr", imem_addr, e.addr);
          chk("wr_data", imem_wdata, e.data);
        end
      end
      if (cpu_reset_n && !prev_rn) rise_cyc = cyc;
    end
    prev_rn = cpu_reset_n;
  end

  // Image = big-endian bytes of words[], optional checksum word, extra bytes.
  task automatic build(bit last, int extra, bit corrupt);
    logic [31:0] x = '0;
    img = {};
    foreach (words[i]) begin
      for (int b = 3; b >= 0; b--) img.push_back(8'(words[i] >> (8*b)));
      x ^= words[i];
    end
`ifdef BOOT_CHECKSUM_EN
    if (last && extra == 0) begin
      if (corrupt) x ^= 32'h1;
      for (int b = 3; b >= 0; b--) img.push_back(8'(x >> (8*b)));
    end
`else
    if (corrupt) x = '0;
`endif
    for (int i = 0; i < extra; i++) img.push_back(8'($urandom));
    has_last = last;
  endtask

  // Reference model: what a correct loader does with this byte image.
  task automatic model();
    int nw = img.size() / 4;
    int rem = img.size() % 4;
    logic [31:0] x = '0, w;
    exp_err = 0; exp_words = 0; n_send = img.size();
    for (int i = 0; i < nw; i++) begin
      w = {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
`ifdef BOOT_CHECKSUM_EN
      if (has_last && rem == 0 && i == nw-1) begin
        exp_err = (w != x);
        break;
      end
`endif
      if (i >= DEPTH) begin
        exp_err = 1; n_send = 4*(i+1);
        break;
      end
      sb.push_back('{addr: i, data: w});
      exp_words++;
      x ^= w;
    end
    if (has_last && rem != 0 && n_send == img.size()) exp_err = 1;
  endtask

  task automatic drive(int max_gap, output int cycles);
    bit ok, r;
    int g;
    cycles = 0;
    for (int i = 0; i < n_send; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (g > 0) begin
        ld_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; cycles++; end
      end
      ld_valid = 1'b1;
      ld_byte  = img[i];
      ld_last  = has_last && (i == img.size()-1);
      ok = 0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk); r = ld_ready;
        @(posedge clk); #1; cycles++;
        if (r) begin ok = 1; break; end
      end
      if (!ok) begin
        chk("ld_ready_timeout", 0, 1);
        ld_valid = 1'b0; ld_last = 1'b0;
        return;
      end
    end
    last_acc_cyc = cyc + 1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic finish_check(string nm);
    int t = 0;
    while (!(boot_done || boot_err) && t < 60) begin @(negedge clk); t++; end
    @(negedge clk); #1;
    chk({nm, "_boot_err"},  boot_err,     exp_err);
    chk({nm, "_boot_done"}, boot_done,    !exp_err);
    chk({nm, "_cpu_rst_n"}, cpu_reset_n,  !exp_err);
    chk({nm, "_words"},     words_loaded, exp_words);
    chk({nm, "_sb_empty"},  sb.size(),    0);
    if (!exp_err) chk({nm, "_release_lat"}, rise_cyc - last_acc_cyc, HOLD+1);
  endtask

  task automatic run_img(string nm, int max_gap, output int cycles);
    model();
    rise_cyc = -1;
    drive(max_gap, cycles);
    finish_check(nm);
  endtask

  task automatic pulse_start(string nm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_rst_n_low"}, cpu_reset_n,  0);
    chk({nm, "_done_low"},  boot_done,    0);
    chk({nm, "_err_low"},   boot_err,     0);
    chk({nm, "_words_clr"}, words_loaded, 0);
    chk({nm, "_ready"},     ld_ready,     1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cycles;
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_imem_we",  imem_we, 0);
    chk("rst_addr",     imem_addr, 0);
    chk("rst_wdata",    imem_wdata, 0);
    chk("rst_words",    words_loaded, 0);
    chk("rst_cpu_rn",   cpu_reset_n, 0);
    chk("rst_done",     boot_done, 0);
    chk("rst_err",      boot_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    words = '{32'h20080005, 32'h8C090004};
    build(1, 0, 0); run_img("normal", 2, cycles);
    pulse_start("reboot1");

    words = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    build(1, 0, 0); run_img("b2b", 0, cycles);
    chk("b2b_no_bubble", cycles, n_send);
    pulse_start("reboot2");

    words = '{32'hDEADBEEF};
    build(1, 2, 0); run_img("misaligned", 1, cycles);
    pulse_start("from_err1");

    words = {};
    for (int i = 0; i < DEPTH+1; i++) words.push_back($urandom);
    build(0, 0, 0); run_img("overflow", 0, cycles);
    pulse_start("from_err2");

    words = {};
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    build(1, 0, 0); run_img("full_depth", 0, cycles);
    pulse_start("reboot3");

    words = '{32'hCAFEF00D};
    build(1, 0, 0); run_img("one_word", 1, cycles);
    pulse_start("reboot4");

    // Reset in the middle of a word: the partial bytes must be discarded.
    words = {};
    build(0, 2, 0); model(); drive(0, cycles);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_words", words_loaded, 0);
    words = '{32'h13572468};
    build(1, 0, 0); run_img("after_midrst", 0, cycles);
    pulse_start("reboot5");

`ifdef BOOT_CHECKSUM_EN
    words = '{32'h11111111, 32'h22222222};
    build(1, 0, 1); run_img("bad_checksum", 1, cycles);
    pulse_start("from_err3");
`endif

    for (int k = 0; k < 5; k++) begin
      words = {};
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) words.push_back($urandom);
      build(1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 0);
      run_img("random", 3, cycles);
      pulse_start("reboot_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
